mem_port_arbiter: RTL and testbench

Shares the core's single memory port between instruction fetch and the load/store unit. It sits between the fetch stage and the data-memory encoder on one side and the external memory interface on the other. Each request follows a req/gnt/rvalid handshake with one outstanding access. Data accesses have priority, and a starvation guard ensures fetch still makes progress.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 52 +++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory handshake bundle for mem_port_arbiter
// fetch  : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
// data   : d_req/d_we/d_addr/d_wdata/d_wstrb in, d_gnt/d_rvalid/d_rdata out
// memory : m_req/m_we/m_addr/m_wdata/m_wstrb out, m_gnt/m_rvalid/m_rdata in
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_gnt, m_rvalid, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_addr, m_wdata, m_wstrb
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_gnt, m_rvalid, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, data first with a fetch starvation guard
// clk, rst_n (async, active-low) : clock and reset
// bus (mem_port_arbiter_if.slave): fetch and data requesters in, memory port out
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t state, state_n;
  logic owner;
  logic [CW-1:0] starve_cnt;
  logic window, any_req, fetch_win;
  // window re-opens on the response cycle so back-to-back accesses need no idle bubble
  always_comb begin
    window = rst_n && (state == IDLE || (state == RSP && bus.m_rvalid));
    any_req = bus.if_req || bus.d_req;
    fetch_win = bus.if_req && (!bus.d_req || starve_cnt == CNT_MAX);
    bus.if_gnt = window && fetch_win;
    bus.d_gnt = window && bus.d_req && !fetch_win;
    bus.if_rvalid = state == RSP && bus.m_rvalid && !owner;
    bus.d_rvalid = state == RSP && bus.m_rvalid && owner;
    bus.m_req = state == REQ;
    state_n = window ? (any_req ? REQ : IDLE) : (state == REQ && bus.m_gnt) ? RSP : state;
  end
  assign bus.if_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= 1'b0;
      starve_cnt <= '0;
      bus.m_we <= 1'b0;
      bus.m_addr <= '0;
      bus.m_wdata <= '0;
      bus.m_wstrb <= '0;
    end else if (window && any_req) begin
      owner <= !fetch_win;
      bus.m_we <= !fetch_win && bus.d_we;
      bus.m_addr <= fetch_win ? bus.if_addr : bus.d_addr;
      bus.m_wdata <= bus.d_wdata;
      bus.m_wstrb <= fetch_win ? 4'h0 : bus.d_wstrb;
      starve_cnt <= (!fetch_win && bus.if_req) ? (starve_cnt == CNT_MAX ? CNT_MAX : starve_cnt + 1'b1) : '0;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.STARVE_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_assert = 0;
  int n_fail = 0;
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic chk_quiet(input string tag);
    chk1({tag, "_if_gnt"}, bus.if_gnt, 1'b0);
    chk1({tag, "_d_gnt"}, bus.d_gnt, 1'b0);
    chk1({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
    chk1({tag, "_d_rvalid"}, bus.d_rvalid, 1'b0);
  endtask
  // transaction-level reference state for the random phase
  bit busy, acc, t_data, t_we, free, e_if, e_d, e_rv, f_gnt_prev, d_gnt_prev;
  logic [31:0] t_addr;
  logic [3:0] t_wstrb;
  int streak, grants, data_run;
  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.d_wstrb = 0; bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = 0;
    // reset state, with requests present that must not be granted
    bus.if_req = 1; bus.d_req = 1;
    smp;
    chk_quiet("reset");
    chk1("reset_m_req", bus.m_req, 1'b0);
    chk1("reset_m_we", bus.m_we, 1'b0);
    chk32("reset_m_addr", bus.m_addr, 32'h0);
    chk32("reset_m_wdata", bus.m_wdata, 32'h0);
    chk32("reset_m_wstrb", 32'(bus.m_wstrb), 32'h0);
    nxt;
    bus.if_req = 0; bus.d_req = 0; rst_n = 1;
    nxt;
    // single fetch
    bus.if_req = 1; bus.if_addr = 32'h100;
    smp;
    chk1("f1_if_gnt", bus.if_gnt, 1'b1);
    chk1("f1_d_gnt", bus.d_gnt, 1'b0);
    nxt;
    bus.if_req = 0; bus.m_gnt = 1;
    smp;
    chk1("f1_m_req", bus.m_req, 1'b1);
    chk32("f1_m_addr", bus.m_addr, 32'h100);
    chk1("f1_m_we", bus.m_we, 1'b0);
    chk1("f1_no_regnt", bus.if_gnt, 1'b0);
    nxt;
    bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hDEADBEEF;
    smp;
    chk1("f1_if_rvalid", bus.if_rvalid, 1'b1);
    chk32("f1_if_rdata", bus.if_rdata, 32'hDEADBEEF);
    chk1("f1_d_rvalid", bus.d_rvalid, 1'b0);
    chk1("f1_m_req_rsp", bus.m_req, 1'b0);
    nxt;
    bus.m_rvalid = 0;
    // simultaneous requests: store first, fetch granted on the store ack
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'h0000BEEF; bus.d_wstrb = 4'h3;
    smp;
    chk1("sim_d_gnt", bus.d_gnt, 1'b1);
    chk1("sim_if_gnt", bus.if_gnt, 1'b0);
    nxt;
    bus.d_req = 0; bus.m_gnt = 1;
    smp;
    chk1("sim_m_req", bus.m_req, 1'b1);
    chk1("sim_m_we", bus.m_we, 1'b1);
    chk32("sim_m_addr", bus.m_addr, 32'h2004);
    chk32("sim_m_wstrb", 32'(bus.m_wstrb), 32'h3);
    chk32("sim_m_wdata", bus.m_wdata, 32'h0000BEEF);
    chk1("sim_if_wait", bus.if_gnt, 1'b0);
    nxt;
    bus.m_gnt = 0; bus.m_rvalid = 1;
    smp;
    chk1("sim_d_rvalid", bus.d_rvalid, 1'b1);
    chk1("sim_if_rvalid", bus.if_rvalid, 1'b0);
    chk1("sim_if_gnt_on_ack", bus.if_gnt, 1'b1);
    chk1("sim_d_gnt_on_ack", bus.d_gnt, 1'b0);
    nxt;
    bus.if_req = 0; bus.m_rvalid = 0; bus.m_gnt = 1;
    smp;
    chk1("sim_f_m_req", bus.m_req, 1'b1);
    chk32("sim_f_m_addr", bus.m_addr, 32'h200);
    chk1("sim_f_m_we", bus.m_we, 1'b0);
    chk32("sim_f_m_wstrb", 32'(bus.m_wstrb), 32'h0);
    nxt;
    bus.m_gnt = 0; bus.m_rvalid = 1;
    smp;
    chk1("sim_f_rvalid", bus.if_rvalid, 1'b1);
    nxt;
    bus.m_rvalid = 0;
    // starvation: both held high, memory always ready; expect 4 data then 1 fetch
    bus.if_req = 1; bus.d_req = 1; bus.d_we = 0; bus.m_gnt = 1; bus.m_rvalid = 1;
    streak = 0; grants = 0; data_run = 0;
    for (int c = 0; c < 24; c++) begin
      smp;
      chk1("stv_excl", bus.if_gnt && bus.d_gnt, 1'b0);
      chk1("stv_cnt_le_max", dut.starve_cnt <= 3'd4, 1'b1);
      if (bus.if_gnt || bus.d_gnt) begin
        grants++;
        chk1("stv_if_gnt", bus.if_gnt, streak == 4);
        streak = (streak == 4) ? 0 : streak + 1;
      end
      nxt;
    end
    chk32("stv_grant_count", 32'(grants), 32'd12);
    bus.if_req = 0; bus.d_req = 0; bus.m_gnt = 0;
    nxt;
    bus.m_rvalid = 0;
    // memory stall: six REQ cycles, requests present must not be granted
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000;
    smp;
    chk1("stl_d_gnt", bus.d_gnt, 1'b1);
    nxt;
    bus.d_addr = 32'h4444; bus.if_req = 1; bus.if_addr = 32'h5550;
    for (int i = 0; i < 6; i++) begin
      bus.m_gnt = (i == 5);
      smp;
      chk1("stl_m_req", bus.m_req, 1'b1);
      chk32("stl_m_addr", bus.m_addr, 32'h3000);
      chk1("stl_m_we", bus.m_we, 1'b0);
      chk1("stl_no_if_gnt", bus.if_gnt, 1'b0);
      chk1("stl_no_d_gnt", bus.d_gnt, 1'b0);
      nxt;
    end
    bus.if_req = 0; bus.d_req = 0; bus.m_gnt = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h12345678;
    smp;
    chk1("stl_d_rvalid", bus.d_rvalid, 1'b1);
    chk32("stl_d_rdata", bus.d_rdata, 32'h12345678);
    chk1("stl_if_rvalid", bus.if_rvalid, 1'b0);
    nxt;
    bus.m_rvalid = 0;
    // reset in the middle of an access
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h5000; bus.d_wdata = 32'hA5A5A5A5; bus.d_wstrb = 4'hF;
    smp;
    chk1("rst_d_gnt", bus.d_gnt, 1'b1);
    nxt;
    bus.d_req = 0; bus.m_gnt = 1;
    smp;
    chk32("rst_m_wdata", bus.m_wdata, 32'hA5A5A5A5);
    nxt;
    bus.m_gnt = 0;
    smp;
    chk1("rst_rsp_m_req", bus.m_req, 1'b0);
    #1 rst_n = 0;
    #1;
    chk_quiet("rst_async");
    chk1("rst_async_m_req", bus.m_req, 1'b0);
    chk1("rst_async_m_we", bus.m_we, 1'b0);
    chk32("rst_async_m_addr", bus.m_addr, 32'h0);
    chk32("rst_async_m_wdata", bus.m_wdata, 32'h0);
    chk32("rst_async_m_wstrb", 32'(bus.m_wstrb), 32'h0);
    nxt;
    nxt;
    rst_n = 1;
    nxt;
    nxt;
    bus.m_rvalid = 1; bus.m_rdata = 32'hBAD0BAD0;
    smp;
    chk_quiet("rst_late_rsp");
    nxt;
    bus.m_rvalid = 0;
    smp;
    chk1("rst_late_m_req", bus.m_req, 1'b0);
    nxt;
    // spurious response in IDLE, then prove the arbiter is still idle
    bus.m_rvalid = 1;
    smp;
    chk_quiet("spur");
    nxt;
    bus.m_rvalid = 0;
    smp;
    chk1("spur_m_req", bus.m_req, 1'b0);
    nxt;
    bus.if_req = 1; bus.if_addr = 32'h600;
    smp;
    chk1("spur_if_gnt", bus.if_gnt, 1'b1);
    nxt;
    bus.if_req = 0; bus.m_gnt = 1;
    smp;
    chk32("spur_m_addr", bus.m_addr, 32'h600);
    nxt;
    bus.m_gnt = 0; bus.m_rvalid = 1;
    smp;
    chk1("spur_if_rvalid", bus.if_rvalid, 1'b1);
    nxt;
    bus.m_rvalid = 0;
    // random traffic against the transaction-level model
    busy = 0; acc = 0; streak = 0; f_gnt_prev = 0; d_gnt_prev = 0;
    t_data = 0; t_we = 0; t_addr = 0; t_wstrb = 0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.if_req || f_gnt_prev) begin
        bus.if_req = $urandom_range(0, 2) != 0;
        bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 9) == 0) bus.if_req = 0;
      if (!bus.d_req || d_gnt_prev) begin
        bus.d_req = $urandom_range(0, 2) != 0;
        bus.d_we = $urandom_range(0, 1) != 0;
        bus.d_addr = $urandom;
        bus.d_wdata = $urandom;
        bus.d_wstrb = 4'($urandom_range(1, 15));
      end
      bus.m_gnt = busy && !acc && $urandom_range(0, 2) != 0;
      bus.m_rvalid = (busy && acc) ? $urandom_range(0, 2) != 0 : $urandom_range(0, 7) == 0;
      bus.m_rdata = $urandom;
      smp;
      free = !busy || (acc && bus.m_rvalid);
      e_if = free && bus.if_req && (!bus.d_req || streak == 4);
      e_d = free && bus.d_req && !e_if;
      e_rv = busy && acc && bus.m_rvalid;
      chk1("rnd_if_gnt", bus.if_gnt, e_if);
      chk1("rnd_d_gnt", bus.d_gnt, e_d);
      chk1("rnd_if_rvalid", bus.if_rvalid, e_rv && !t_data);
      chk1("rnd_d_rvalid", bus.d_rvalid, e_rv && t_data);
      chk1("rnd_m_req", bus.m_req, busy && !acc);
      chk32("rnd_if_rdata", bus.if_rdata, bus.m_rdata);
      chk32("rnd_d_rdata", bus.d_rdata, bus.m_rdata);
      if (busy && !acc) begin
        chk32("rnd_m_addr", bus.m_addr, t_addr);
        chk1("rnd_m_we", bus.m_we, t_we);
        if (!t_data || t_we) chk32("rnd_m_wstrb", 32'(bus.m_wstrb), 32'(t_wstrb));
      end
      f_gnt_prev = e_if;
      d_gnt_prev = e_d;
      if (e_rv) busy = 0;
      if (busy && !acc && bus.m_gnt) acc = 1;
      if (e_if || e_d) begin
        busy = 1; acc = 0; t_data = e_d;
        t_addr = e_if ? bus.if_addr : bus.d_addr;
        t_we = e_d && bus.d_we;
        t_wstrb = e_d ? bus.d_wstrb : 4'h0;
        streak = (e_d && bus.if_req) ? ((streak == 4) ? 4 : streak + 1) : 0;
      end
      nxt;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
